// File: rtl/complement_pkg.sv
// Shared divider package.
//
// Holds the default operand width and a two's-complement negate helper. The helper works on a
// fixed MaxWidth-bit container so any stage of any width up to MaxWidth can reuse it: callers
// zero-extend their operand, negate, and keep the low WIDTH bits. Carries only propagate upward,
// so those low bits equal (~x + 1) mod 2^WIDTH.
package complement_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned MaxWidth     = 128;

  function automatic logic [MaxWidth-1:0] twos_negate(input logic [MaxWidth-1:0] x);
    return (~x) + {{(MaxWidth-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/complement_abs_value.sv
// Combinational absolute value of a signed two's-complement operand.
//
// Ports:
//   x_i         operand, two's complement, WIDTH bits
//   magnitude_o unsigned |x|; the minimum negative value maps to 2^(WIDTH-1)
//   is_zero_o   operand equals zero
//   is_neg_o    operand sign bit
//
// WIDTH must be in the range 2..MaxWidth.
module complement_abs_value
  import complement_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] magnitude_o,
  output logic             is_zero_o,
  output logic             is_neg_o
);

  logic [MaxWidth-1:0] x_ext;
  logic [MaxWidth-1:0] neg_ext;
  logic                unused_neg_hi;

  always_comb begin
    x_ext            = '0;
    x_ext[WIDTH-1:0] = x_i;
  end

  assign neg_ext = twos_negate(x_ext);

  // Only the low WIDTH bits of the wide negate are meaningful.
  assign unused_neg_hi = ^neg_ext;

  assign is_neg_o    = x_i[WIDTH-1];
  assign magnitude_o = is_neg_o ? neg_ext[WIDTH-1:0] : x_i;
  assign is_zero_o   = (x_i == '0);

endmodule

// File: rtl/complement.sv
// Operand-conditioning stage at the front of the signed integer divider.
//
// Converts signed dividend/divisor into unsigned magnitudes, flags zero operands and produces
// the sign-fixup bits the divider core needs. One registered stage, 1-cycle latency, no
// backpressure; out_valid pulses for one cycle per captured operand pair.
//
// Ports:
//   clock, reset   rising-edge clock; asynchronous active-high reset
//   in_valid       capture A/B on this edge
//   A, B           signed dividend / divisor
//   out_valid      outputs hold the result of the operands captured on the last edge
//   aZero, bZero   captured A / B equal zero
//   dividend       |A|
//   divisor        |B|
//   negQuotient    quotient must be negated (sign mismatch, both operands non-zero)
//   negRemainder   remainder must be negated (A negative and non-zero)
module complement
  import complement_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             aZero,
  output logic             bZero,
  output logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] divisor,
  output logic             negQuotient,
  output logic             negRemainder
);

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_zero, b_zero;
  logic             a_neg, b_neg;

  complement_abs_value #(
    .WIDTH (WIDTH)
  ) u_abs_a (
    .x_i         (A),
    .magnitude_o (a_mag),
    .is_zero_o   (a_zero),
    .is_neg_o    (a_neg)
  );

  complement_abs_value #(
    .WIDTH (WIDTH)
  ) u_abs_b (
    .x_i         (B),
    .magnitude_o (b_mag),
    .is_zero_o   (b_zero),
    .is_neg_o    (b_neg)
  );

  logic             out_valid_q, out_valid_d;
  logic             a_zero_q, a_zero_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

  always_comb begin
    out_valid_d = in_valid;
    a_zero_d    = a_zero_q;
    b_zero_d    = b_zero_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    if (in_valid) begin
      a_zero_d   = a_zero;
      b_zero_d   = b_zero;
      dividend_d = a_mag;
      divisor_d  = b_mag;
      // A zero result carries no sign; divide-by-zero is handled by the core, not negated.
      neg_quot_d = (a_neg ^ b_neg) & ~a_zero & ~b_zero;
      neg_rem_d  = a_neg & ~a_zero;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      a_zero_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      a_zero_q    <= a_zero_d;
      b_zero_q    <= b_zero_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign aZero        = a_zero_q;
  assign bZero        = b_zero_q;
  assign dividend     = dividend_q;
  assign divisor      = divisor_q;
  assign negQuotient  = neg_quot_q;
  assign negRemainder = neg_rem_q;

endmodule

// File: tb/tb_complement.sv
// Self-checking bench for the divider operand-conditioning stage.
module tb_complement;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] A, B;
  logic         out_valid, aZero, bZero, negQuotient, negRemainder;
  logic [W-1:0] dividend, divisor;

  complement #(
    .WIDTH (W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .A            (A),
    .B            (B),
    .out_valid    (out_valid),
    .aZero        (aZero),
    .bZero        (bZero),
    .dividend     (dividend),
    .divisor      (divisor),
    .negQuotient  (negQuotient),
    .negRemainder (negRemainder)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state: what the outputs should show right now.
  logic         m_valid, m_az, m_bz, m_nq, m_nr;
  logic [W-1:0] m_dd, m_dv;

  // Magnitude via plain signed arithmetic in a wider integer.
  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] x);
    longint v;
    v = longint'($signed(x));
    if (v < 0) v = -v;
    return v[W-1:0];
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("out_valid", W'(out_valid), W'(m_valid));
    check_val("aZero", W'(aZero), W'(m_az));
    check_val("bZero", W'(bZero), W'(m_bz));
    check_val("dividend", dividend, m_dd);
    check_val("divisor", divisor, m_dv);
    check_val("negQuotient", W'(negQuotient), W'(m_nq));
    check_val("negRemainder", W'(negRemainder), W'(m_nr));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_az = 1'b0; m_bz = 1'b0;
    m_dd = '0; m_dv = '0; m_nq = 1'b0; m_nr = 1'b0;
  endtask

  // One cycle: drive at negedge, model the capture, check just after the rising edge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    @(negedge clock);
    in_valid = v; A = a; B = b;
    @(posedge clock);
    if (v) begin
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      m_az = (sa == 0);
      m_bz = (sb == 0);
      m_dd = ref_mag(a);
      m_dv = ref_mag(b);
      m_nq = (sa != 0) && (sb != 0) && ((sa < 0) != (sb < 0));
      m_nr = (sa < 0);
    end
    m_valid = v;
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'(W'($urandom_range(0, 20)) - 32'd10);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 1'b0;

    // Directed cases with a few hard-coded expectations.
    step(1'b1, 32'd2, -32'sd4);
    check_val("tp_2_m4_divisor", divisor, 32'd4);
    check_val("tp_2_m4_negq", W'(negQuotient), 32'd1);
    step(1'b1, -32'sd15, -32'sd15);
    check_val("tp_m15_negr", W'(negRemainder), 32'd1);
    step(1'b1, 32'd0, 32'd8);
    check_val("tp_azero", W'(aZero), 32'd1);
    step(1'b1, 32'd100, 32'd0);
    check_val("tp_bzero", W'(bZero), 32'd1);
    step(1'b1, -32'sd10, 32'd3);
    check_val("tp_m10_dividend", dividend, 32'd10);
    step(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("tp_minneg", dividend, 32'h8000_0000);
    step(1'b1, 32'd0, 32'd0);
    check_val("tp_both_zero_negq", W'(negQuotient), 32'd0);

    // Back-to-back captures, then hold.
    step(1'b1, 32'd7, -32'sd1);
    step(1'b1, -32'sd7, 32'd1);
    step(1'b1, -32'sd7, -32'sd1);
    check_val("tp_b2b_negq", W'(negQuotient), 32'd0);
    step(1'b0, 32'd123, 32'd456);
    step(1'b0, 32'd9, 32'd9);

    // Asynchronous reset between edges while out_valid is high.
    step(1'b1, 32'd5, -32'sd3);
    #2;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 32'd77, 32'd88);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      step(logic'($urandom_range(0, 3) != 0), pick_operand(), pick_operand());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
